// File: rtl/hqm_qed_rf_pg_ctl_if.sv
// Functional request/response bundle between the QED pipeline and the RF power-gate controller.
interface hqm_qed_rf_pg_ctl_if #(
    parameter int AW = 2,
    parameter int DW = 45
);
    logic          wr_v;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_rdy;
    logic          rd_v;
    logic [AW-1:0] rd_addr;
    logic          rd_rdy;
    logic          rd_data_v;
    logic [DW-1:0] rd_data;

    modport master (
        output wr_v, wr_addr, wr_data, rd_v, rd_addr,
        input  wr_rdy, rd_rdy, rd_data_v, rd_data
    );

    modport slave (
        input  wr_v, wr_addr, wr_data, rd_v, rd_addr,
        output wr_rdy, rd_rdy, rd_data_v, rd_data
    );
endinterface

// File: rtl/hqm_qed_rf_pg_ctl.sv
// Power-gate sequencer and access controller for a small power-gated 2-port RF.
// Optional stored parity bit and read parity check: define HQM_QED_RF_PG_PARITY_EN.
module hqm_qed_rf_pg_ctl #(
    parameter int DEPTH    = 4,
    parameter int AW       = 2,
    parameter int DW       = 45,
    parameter int IDLE_CYC = 64,
    parameter int PWR_TMO  = 16,
`ifdef HQM_QED_RF_PG_PARITY_EN
    localparam int MW = DW + 1
`else
    localparam int MW = DW
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hqm_qed_rf_pg_ctl_if.slave   qed,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_waddr,
    output logic [MW-1:0]        mem_wdata,
    output logic                 mem_re,
    output logic [AW-1:0]        mem_raddr,
    input  logic [MW-1:0]        mem_rdata,
    output logic                 pgcb_isol_en,
    output logic                 pwr_enable_b,
    input  logic                 pwr_enable_b_ack,
    output logic                 pwr_on,
    output logic                 pwr_err,
    output logic                 par_err
);

    localparam int TW = (PWR_TMO > 0) ? $clog2(PWR_TMO + 1) : 1;
    localparam int IW = (IDLE_CYC > 0) ? $clog2(IDLE_CYC + 1) : 1;

    typedef enum logic [2:0] {OFF, PUP, DEISO, INIT, ACTIVE, ISO, PDN} state_t;

    state_t        state_r;
    logic [TW-1:0] timer_r;
    logic [AW-1:0] addr_cnt_r;
    logic [IW-1:0] idle_r;
    logic          rdy_r;
    logic          pwr_on_r;
    logic          pwr_en_b_r;
    logic          isol_r;
    logic          pwr_err_r;
    logic          rd_data_v_r;

    logic          req_s;
    logic          wr_acc_s;
    logic          rd_acc_s;
    logic          tmo_s;
    logic          idle_hit_s;

    function automatic logic even_par(input logic [DW-1:0] d);
        return ^d;
    endfunction

    assign req_s      = qed.wr_v | qed.rd_v;
    assign wr_acc_s   = qed.wr_v & rdy_r;
    assign rd_acc_s   = qed.rd_v & rdy_r;
    assign tmo_s      = (timer_r <= TW'(1));
    assign idle_hit_s = (idle_r >= IW'(IDLE_CYC - 1));

    // Memory port steering: INIT zero-fill, otherwise the accepted functional request.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        mem_re    = 1'b0;
        mem_raddr = '0;
        if (state_r == INIT) begin
            mem_we    = 1'b1;
            mem_waddr = addr_cnt_r;
        end else if (wr_acc_s) begin
            mem_we    = 1'b1;
            mem_waddr = qed.wr_addr;
`ifdef HQM_QED_RF_PG_PARITY_EN
            mem_wdata = {even_par(qed.wr_data), qed.wr_data};
`else
            mem_wdata = qed.wr_data;
`endif
        end else begin
            mem_we    = 1'b0;
        end
        if (rd_acc_s) begin
            mem_re    = 1'b1;
            mem_raddr = qed.rd_addr;
        end else begin
            mem_re    = 1'b0;
        end
    end

    // Power sequencing FSM with registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= OFF;
            timer_r     <= '0;
            addr_cnt_r  <= '0;
            idle_r      <= '0;
            rdy_r       <= 1'b0;
            pwr_on_r    <= 1'b0;
            pwr_en_b_r  <= 1'b1;
            isol_r      <= 1'b1;
            pwr_err_r   <= 1'b0;
            rd_data_v_r <= 1'b0;
        end else begin
            rd_data_v_r <= rd_acc_s;
            case (state_r)
                OFF: begin
                    if (req_s) begin
                        state_r    <= PUP;
                        pwr_en_b_r <= 1'b0;
                        timer_r    <= TW'(PWR_TMO);
                    end
                end
                PUP: begin
                    if (!pwr_enable_b_ack) begin
                        state_r <= DEISO;
                        isol_r  <= 1'b0;
                    end else if (tmo_s) begin
                        state_r    <= OFF;
                        pwr_err_r  <= 1'b1;
                        pwr_en_b_r <= 1'b1;
                    end else begin
                        timer_r <= timer_r - TW'(1);
                    end
                end
                DEISO: begin
                    state_r    <= INIT;
                    addr_cnt_r <= '0;
                end
                INIT: begin
                    if (addr_cnt_r == AW'(DEPTH - 1)) begin
                        state_r    <= ACTIVE;
                        addr_cnt_r <= '0;
                        rdy_r      <= 1'b1;
                        pwr_on_r   <= 1'b1;
                        idle_r     <= '0;
                    end else begin
                        addr_cnt_r <= addr_cnt_r + AW'(1);
                    end
                end
                ACTIVE: begin
                    // Leave only on a cycle with no request, so nothing is accepted on exit.
                    if (req_s) begin
                        idle_r <= '0;
                    end else if ((IDLE_CYC != 0) && idle_hit_s && !rd_data_v_r) begin
                        state_r  <= ISO;
                        rdy_r    <= 1'b0;
                        pwr_on_r <= 1'b0;
                        isol_r   <= 1'b1;
                        idle_r   <= IW'(IDLE_CYC);
                    end else if (idle_hit_s) begin
                        idle_r <= IW'(IDLE_CYC);
                    end else begin
                        idle_r <= idle_r + IW'(1);
                    end
                end
                ISO: begin
                    state_r    <= PDN;
                    pwr_en_b_r <= 1'b1;
                    timer_r    <= TW'(PWR_TMO);
                end
                PDN: begin
                    if (pwr_enable_b_ack) begin
                        state_r <= OFF;
                    end else if (tmo_s) begin
                        state_r   <= OFF;
                        pwr_err_r <= 1'b1;
                    end else begin
                        timer_r <= timer_r - TW'(1);
                    end
                end
                default: begin
                    state_r    <= OFF;
                    rdy_r      <= 1'b0;
                    pwr_on_r   <= 1'b0;
                    pwr_en_b_r <= 1'b1;
                    isol_r     <= 1'b1;
                end
            endcase
        end
    end

    // The RF returns data one cycle after mem_re, so read data is presented straight from it.
    assign qed.wr_rdy    = rdy_r;
    assign qed.rd_rdy    = rdy_r;
    assign qed.rd_data_v = rd_data_v_r;
    assign qed.rd_data   = rd_data_v_r ? mem_rdata[DW-1:0] : '0;
    assign pgcb_isol_en  = isol_r;
    assign pwr_enable_b  = pwr_en_b_r;
    assign pwr_on        = pwr_on_r;
    assign pwr_err       = pwr_err_r;
`ifdef HQM_QED_RF_PG_PARITY_EN
    assign par_err       = rd_data_v_r & (^mem_rdata);
`else
    assign par_err       = 1'b0;
`endif

endmodule

// File: tb/tb_hqm_qed_rf_pg_ctl.sv
// Directed self-checking bench for hqm_qed_rf_pg_ctl with a behavioural read-before-write RF.
module tb_hqm_qed_rf_pg_ctl;

`ifdef HQM_QED_RF_PG_PARITY_EN
    localparam int MW = 46;
`else
    localparam int MW = 45;
`endif
    localparam logic [44:0] D1 = 45'h1_2345_6789;

    logic          clk;
    logic          rst_n;
    logic          mem_we;
    logic [1:0]    mem_waddr;
    logic [MW-1:0] mem_wdata;
    logic          mem_re;
    logic [1:0]    mem_raddr;
    logic [MW-1:0] mem_rdata;
    logic          pgcb_isol_en;
    logic          pwr_enable_b;
    logic          pwr_enable_b_ack;
    logic          pwr_on;
    logic          pwr_err;
    logic          par_err;
    logic          flip;
    logic [MW-1:0] mem_q [4];
    logic [MW-1:0] rdata_q;
    logic [MW-1:0] exp_wd;

    int n_vec;
    int n_err;

    hqm_qed_rf_pg_ctl_if #(.AW(2), .DW(45)) qed_if ();

    hqm_qed_rf_pg_ctl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .qed              (qed_if),
        .mem_we           (mem_we),
        .mem_waddr        (mem_waddr),
        .mem_wdata        (mem_wdata),
        .mem_re           (mem_re),
        .mem_raddr        (mem_raddr),
        .mem_rdata        (mem_rdata),
        .pgcb_isol_en     (pgcb_isol_en),
        .pwr_enable_b     (pwr_enable_b),
        .pwr_enable_b_ack (pwr_enable_b_ack),
        .pwr_on           (pwr_on),
        .pwr_err          (pwr_err),
        .par_err          (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RF model: registered read, read-before-write, garbage contents until zero-filled.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= MW'(64'h1555_AAAA_3C3C) ^ MW'(i);
            rdata_q <= '0;
        end else begin
            if (mem_re) rdata_q <= mem_q[mem_raddr];
            if (mem_we) mem_q[mem_waddr] <= mem_wdata;
        end
    end
    assign mem_rdata = rdata_q ^ MW'(flip);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        flip  = 1'b0;
        pwr_enable_b_ack = 1'b1;
        qed_if.wr_v = 1'b0; qed_if.wr_addr = 2'd0; qed_if.wr_data = 45'd0;
        qed_if.rd_v = 1'b0; qed_if.rd_addr = 2'd0;
`ifdef HQM_QED_RF_PG_PARITY_EN
        exp_wd = {^D1, D1};
`else
        exp_wd = D1;
`endif
        repeat (3) go();
        chk("rst_pwr_en_b", 64'(pwr_enable_b), 64'd1);
        chk("rst_isol", 64'(pgcb_isol_en), 64'd1);
        chk("rst_pwr_on", 64'(pwr_on), 64'd0);
        chk("rst_wr_rdy", 64'(qed_if.wr_rdy), 64'd0);
        chk("rst_rd_dv", 64'(qed_if.rd_data_v), 64'd0);
        chk("rst_rd_data", 64'(qed_if.rd_data), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_errs", {62'd0, pwr_err, par_err}, 64'd0);
        rst_n = 1'b1;

        // Wake-up by a write request
        go();
        qed_if.wr_v = 1'b1; qed_if.wr_addr = 2'd2; qed_if.wr_data = D1;
        #1;
        chk("off_pwr_en_b", 64'(pwr_enable_b), 64'd1);
        chk("off_wr_rdy", 64'(qed_if.wr_rdy), 64'd0);
        chk("off_mem_we", 64'(mem_we), 64'd0);
        go();
        chk("pup_pwr_en_b", 64'(pwr_enable_b), 64'd0);
        chk("pup_isol", 64'(pgcb_isol_en), 64'd1);
        go();
        go();
        pwr_enable_b_ack = 1'b0;
        go();
        #1;
        chk("deiso_isol", 64'(pgcb_isol_en), 64'd0);
        chk("deiso_mem_we", 64'(mem_we), 64'd0);
        chk("deiso_wr_rdy", 64'(qed_if.wr_rdy), 64'd0);
        for (int i = 0; i < 4; i++) begin
            go();
            #1;
            chk("init_we", 64'(mem_we), 64'd1);
            chk("init_waddr", 64'(mem_waddr), 64'(i));
            chk("init_wdata", 64'(mem_wdata), 64'd0);
            chk("init_wr_rdy", 64'(qed_if.wr_rdy), 64'd0);
        end
        go();
        #1;
        chk("act_wr_rdy", 64'(qed_if.wr_rdy), 64'd1);
        chk("act_pwr_on", 64'(pwr_on), 64'd1);
        chk("act_we", 64'(mem_we), 64'd1);
        chk("act_waddr", 64'(mem_waddr), 64'd2);
        chk("act_wdata", 64'(mem_wdata), 64'(exp_wd));

        // Reads: written data and an init value
        go();
        qed_if.wr_v = 1'b0; qed_if.rd_v = 1'b1; qed_if.rd_addr = 2'd2;
        #1;
        chk("rd_re", 64'(mem_re), 64'd1);
        chk("rd_raddr", 64'(mem_raddr), 64'd2);
        chk("rd_dv_early", 64'(qed_if.rd_data_v), 64'd0);
        go();
        qed_if.rd_addr = 2'd1;
        #1;
        chk("rd2_dv", 64'(qed_if.rd_data_v), 64'd1);
        chk("rd2_data", 64'(qed_if.rd_data), 64'(D1));
        chk("rd2_par", 64'(par_err), 64'd0);
        go();
        qed_if.rd_v = 1'b0;
        #1;
        chk("rd1_dv", 64'(qed_if.rd_data_v), 64'd1);
        chk("rd1_data", 64'(qed_if.rd_data), 64'd0);
        go();
        chk("rd_dv_idle", 64'(qed_if.rd_data_v), 64'd0);

        // Same-cycle read and write to one address
        qed_if.wr_v = 1'b1; qed_if.wr_addr = 2'd3; qed_if.wr_data = 45'h7;
        qed_if.rd_v = 1'b1; qed_if.rd_addr = 2'd3;
        #1;
        chk("rw_we", 64'(mem_we), 64'd1);
        chk("rw_re", 64'(mem_re), 64'd1);
        go();
        qed_if.wr_v = 1'b0;
        #1;
        chk("rw_old_data", 64'(qed_if.rd_data), 64'd0);
        go();
        qed_if.rd_v = 1'b0;
        #1;
        chk("rw_new_data", 64'(qed_if.rd_data), 64'h7);

`ifdef HQM_QED_RF_PG_PARITY_EN
        // Corrupted read data bit 0 must flag a parity error for exactly one cycle
        go();
        qed_if.rd_v = 1'b1; qed_if.rd_addr = 2'd2;
        go();
        qed_if.rd_v = 1'b0; flip = 1'b1;
        #1;
        chk("par_dv", 64'(qed_if.rd_data_v), 64'd1);
        chk("par_err_hi", 64'(par_err), 64'd1);
        go();
        chk("par_err_lo", 64'(par_err), 64'd0);
        flip = 1'b0;
`endif

        // Idle power-down: last request in cycle R, ISO entered in R+65
        go();
        qed_if.rd_v = 1'b1; qed_if.rd_addr = 2'd0;
        go();
        qed_if.rd_v = 1'b0;
        repeat (63) go();
        chk("idle_pwr_on", 64'(pwr_on), 64'd1);
        chk("idle_isol", 64'(pgcb_isol_en), 64'd0);
        go();
        chk("iso_isol", 64'(pgcb_isol_en), 64'd1);
        chk("iso_pwr_on", 64'(pwr_on), 64'd0);
        chk("iso_wr_rdy", 64'(qed_if.wr_rdy), 64'd0);
        chk("iso_pwr_en_b", 64'(pwr_enable_b), 64'd0);
        go();
        chk("pdn_pwr_en_b", 64'(pwr_enable_b), 64'd1);
        go();
        pwr_enable_b_ack = 1'b1;
        go();
        chk("off2_isol", 64'(pgcb_isol_en), 64'd1);
        chk("off2_pwr_on", 64'(pwr_on), 64'd0);
        chk("off2_pwr_err", 64'(pwr_err), 64'd0);

        // Power-up acknowledge timeout, then retry
        go();
        qed_if.wr_v = 1'b1; qed_if.wr_addr = 2'd0; qed_if.wr_data = 45'h5;
        #1;
        chk("tmo_off", 64'(pwr_enable_b), 64'd1);
        go();
        chk("tmo_pup", 64'(pwr_enable_b), 64'd0);
        repeat (15) go();
        chk("tmo_not_yet", 64'(pwr_err), 64'd0);
        chk("tmo_still_on", 64'(pwr_enable_b), 64'd0);
        go();
        chk("tmo_err", 64'(pwr_err), 64'd1);
        chk("tmo_pwr_off", 64'(pwr_enable_b), 64'd1);
        go();
        chk("retry_pup", 64'(pwr_enable_b), 64'd0);
        chk("retry_err_sticky", 64'(pwr_err), 64'd1);

        // Reset mid power-up restores power-off state and clears the error
        rst_n = 1'b0;
        qed_if.wr_v = 1'b0;
        #1;
        chk("rst2_pwr_en_b", 64'(pwr_enable_b), 64'd1);
        chk("rst2_isol", 64'(pgcb_isol_en), 64'd1);
        chk("rst2_pwr_err", 64'(pwr_err), 64'd0);
        go();
        rst_n = 1'b1;
        go();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hqm_qed_rf_pg_ctl.md
Name: hqm_qed_rf_pg_ctl

Overview:
- Power-gate sequencer and access controller for a small power-gated 2-port register file (default 4x45) in the QED pipeline.
- Wakes the RF on demand: drives the power enable and isolation, zero-initialises every entry after power-up, gates functional read/write traffic with valid/ready, and powers the RF down after an idle timeout.
- Sits between the QED functional logic and the RF memory wrapper, in the same clock domain as both memory ports.

Parameters:
- DEPTH, 4, number of RF entries
- AW, 2, address width; equals clog2(DEPTH)
- DW, 45, functional data width
- IDLE_CYC, 64, consecutive idle ACTIVE cycles before power-down; 0 disables auto power-down
- PWR_TMO, 16, maximum cycles to wait for pwr_enable_b_out acknowledge

Ports:
- clk  in  1  single clock; drives the RF wclk and rclk
- rst_n  in  1  asynchronous active-low reset
- wr_v  in  1  write request valid
- wr_addr  in  AW  write address
- wr_data  in  DW  write data
- wr_rdy  out  1  write accepted when wr_v & wr_rdy
- rd_v  in  1  read request valid
- rd_addr  in  AW  read address
- rd_rdy  out  1  read accepted when rd_v & rd_rdy
- rd_data_v  out  1  read data valid, one cycle after read accept
- rd_data  out  DW  read data
- mem_we  out  1  RF write enable
- mem_waddr  out  AW  RF write address
- mem_wdata  out  DW (DW+1 with parity)  RF write data
- mem_re  out  1  RF read enable
- mem_raddr  out  AW  RF read address
- mem_rdata  in  DW (DW+1 with parity)  RF read data
- pgcb_isol_en  out  1  RF isolation, 1 = isolated
- pwr_enable_b  out  1  RF power enable, 0 = powered
- pwr_enable_b_ack  in  1  RF power-enable chain return
- pwr_on  out  1  RF is in ACTIVE
- pwr_err  out  1  sticky; acknowledge timeout
- par_err  out  1  parity error pulse (see Optional Feature)

Behaviour:
- Reset values:
  - state = OFF
  - pwr_enable_b = 1, pgcb_isol_en = 1
  - all other outputs 0
  - rd_data = 0
- FSM states: OFF, PUP, DEISO, INIT, ACTIVE, ISO, PDN.
- OFF:
  - wr_v | rd_v -> PUP; pwr_enable_b drives 0 in the cycle PUP is entered.
  - No request -> stay in OFF.
- PUP:
  - Load timer with PWR_TMO; wait for pwr_enable_b_ack == 0, then -> DEISO.
  - Timer reaches 0 first -> set pwr_err, drive pwr_enable_b = 1, -> OFF.
- DEISO: pgcb_isol_en drops to 0; stay one cycle, then -> INIT.
- INIT:
  - mem_we = 1, mem_wdata = 0; mem_waddr counts 0..DEPTH-1, one entry per cycle.
  - After the last entry (DEPTH cycles) -> ACTIVE.
- ACTIVE:
  - pwr_on = 1; wr_rdy = rd_rdy = 1.
  - mem_we/mem_waddr/mem_wdata and mem_re/mem_raddr follow the accepted request combinationally.
  - rd_data_v = 1 and rd_data = mem_rdata on the cycle after a read accept.
  - Idle counter: cleared on any request; incremented otherwise.
  - Counter reaches IDLE_CYC (IDLE_CYC != 0) with no read in flight -> ISO.
- ISO: pgcb_isol_en = 1; one cycle, then -> PDN.
- PDN:
  - pwr_enable_b = 1; wait for pwr_enable_b_ack == 1 (timeout as in PUP, sets pwr_err) -> OFF.
- wr_rdy and rd_rdy are 0 in every state except ACTIVE. Requests arriving in ISO or PDN are held by the requester and cause re-entry to PUP after OFF.
- Simultaneous read and write to the same address in one cycle: both are accepted; read returns the old data (RF read-before-write semantics).
- Idle counter saturates at IDLE_CYC; the address counter wraps at DEPTH-1.
- rst_n asserted in any state: immediate return to reset values, i.e. RF isolated and powered off. No partial INIT state is retained.
- pwr_err is cleared only by reset.

Optional Feature:
- Macro: HQM_QED_RF_PG_PARITY_EN.
- Defined:
  - mem_wdata/mem_rdata are DW+1 bits; bit DW = even parity of the data bits.
  - INIT writes all zeros, which is valid parity.
  - On each rd_data_v, par_err pulses for one cycle if the parity over mem_rdata[DW:0] is odd.
- Undefined:
  - mem widths are DW; par_err is tied 0.

Test Plan:
- Reset, then wr_v=1 addr=2 data=45'h1_2345_6789 -> pwr_enable_b falls next cycle; ack=0 after 3 cycles -> DEISO, then 4 INIT writes of 0 to addr 0..3, then wr_rdy=1 and mem_we with addr 2.
- ACTIVE: read addr 2 -> rd_data_v one cycle later, rd_data=45'h1_2345_6789. Read addr 1 -> 0 (init value).
- Same-cycle write addr 3=45'h7 and read addr 3 -> rd_data=0; next read of addr 3 -> 45'h7.
- IDLE_CYC=64, no requests -> ISO after 64 cycles, then PDN; ack=1 -> OFF, pwr_on=0, pgcb_isol_en=1.
- PUP with ack held at 1 for PWR_TMO=16 cycles -> pwr_err=1, pwr_enable_b=1, back to OFF; a new request retries PUP.
- With HQM_QED_RF_PG_PARITY_EN: force mem_rdata bit 0 flipped on a read of addr 2 -> par_err=1 for exactly one cycle, coincident with rd_data_v.
